// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI read-channel constants and read FSM state type
package axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  typedef enum logic {IDLE, BURST} rd_state_t;
endpackage

// File: rtl/axi_mem_read_slave_if.sv
// axi_mem_read_slave_if: AXI4 AR and R channel bundle with master/slave views
// ports: AR (valid/ready/addr/len/size/burst/id), R (valid/ready/data/resp/last/id)
interface axi_mem_read_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                  s_arvalid;
  logic                  s_arready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [7:0]            s_arlen;
  logic [2:0]            s_arsize;
  logic [1:0]            s_arburst;
  logic [ID_WIDTH-1:0]   s_arid;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rlast;
  logic [ID_WIDTH-1:0]   s_rid;
  modport slave (
    input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid, s_rready,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid
  );
  modport master (
    output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid, s_rready,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid
  );
endinterface

// File: rtl/axi_mem_read_slave.sv
// axi_mem_read_slave: AXI4 burst read slave driving a combinational memory read port
// ports: clk, rst_n (async active-low), bus (AXI AR/R slave view),
//        mem_addr (byte address of the current beat), mem_rd (same-cycle read data)
module axi_mem_read_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_REAL_WIDTH = 18,
  parameter int ID_WIDTH        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi_mem_read_slave_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd
);
  rd_state_t           state;
  logic [7:0]          len;
  logic [7:0]          beat;
  logic                fixed;
  logic                err;
  logic [ID_WIDTH-1:0] id;
  logic                load;
  logic                bad;
  assign load = state == BURST && (!bus.s_rvalid || bus.s_rready);
  // beats addressed beyond the memory, or of an unsupported request, return SLVERR
  assign bad  = err || |mem_addr[ADDR_WIDTH-1:ADDR_REAL_WIDTH+2];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.s_arready <= 1'b0;
      bus.s_rvalid  <= 1'b0;
      bus.s_rdata   <= '0;
      bus.s_rresp   <= RESP_OKAY;
      bus.s_rlast   <= 1'b0;
      bus.s_rid     <= '0;
      mem_addr      <= '0;
      len           <= '0;
      beat          <= '0;
      fixed         <= 1'b0;
      err           <= 1'b0;
      id            <= '0;
    end else begin
      // a beat consumed with no replacement empties the R register; a load below overrides
      if (bus.s_rready) bus.s_rvalid <= 1'b0;
      if (state == IDLE) begin
        bus.s_arready <= 1'b1;
        if (bus.s_arvalid && bus.s_arready) begin
          mem_addr      <= bus.s_araddr & ~ADDR_WIDTH'(3);
          len           <= bus.s_arlen;
          fixed         <= bus.s_arburst == BURST_FIXED;
          err           <= bus.s_arsize != SIZE_4B || bus.s_arburst == BURST_WRAP || bus.s_arburst == 2'b11;
          id            <= bus.s_arid;
          beat          <= '0;
          bus.s_arready <= 1'b0;
          state         <= BURST;
        end
      end else if (load) begin
        bus.s_rvalid <= 1'b1;
        bus.s_rdata  <= bad ? '0 : mem_rd;
        bus.s_rresp  <= bad ? RESP_SLVERR : RESP_OKAY;
        bus.s_rlast  <= beat == len;
        bus.s_rid    <= id;
        beat         <= beat + 8'd1;
        mem_addr     <= fixed ? mem_addr : mem_addr + ADDR_WIDTH'(4);
        if (beat == len) begin
          state         <= IDLE;
          bus.s_arready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_read_slave.sv
// tb_axi_mem_read_slave: directed table plus randomized bursts against a burst-level model
module tb_axi_mem_read_slave;
  import axi_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd;
  logic [31:0] mem [0:262143];
  int          n_cmp = 0;
  int          n_err = 0;
  axi_mem_read_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus();
  axi_mem_read_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_REAL_WIDTH(18), .ID_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mem_addr(mem_addr), .mem_rd(mem_rd)
  );
  always #5 clk = ~clk;
  assign mem_rd = mem[mem_addr[19:2]];
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    int          mode;
    bit          lat;
    logic [31:0] d0;
    logic [1:0]  r0;
    logic [31:0] dl;
    logic [1:0]  rl;
  } vec_t;
  vec_t tv [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input int mode, input bit lat_chk,
                         output logic [31:0] d0, output logic [1:0] r0, output logic [31:0] dl, output logic [1:0] rl);
    logic [31:0] ed[$];
    logic [1:0]  er[$];
    logic [31:0] sd, sa;
    logic [1:0]  sr;
    logic        sl;
    logic [3:0]  si;
    int          got, cyc, t, since;
    bit          stalled, seen, rr;
    got = 0; cyc = 0; t = 0; since = 0; stalled = 0; seen = 0;
    sd = '0; sa = '0; sr = '0; sl = 1'b0; si = '0;
    d0 = '0; r0 = '0; dl = '0; rl = '0;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a;
      bit          b;
      a = (addr & ~32'd3) + (burst == BURST_FIXED ? 32'd0 : 32'(4 * i));
      b = size != SIZE_4B || burst >= BURST_WRAP || a >= 32'h0010_0000;
      ed.push_back(b ? 32'd0 : mem[a[19:2]]);
      er.push_back(b ? RESP_SLVERR : RESP_OKAY);
    end
    @(negedge clk);
    bus.s_arvalid = 1'b1; bus.s_araddr = addr; bus.s_arlen = len;
    bus.s_arsize = size; bus.s_arburst = burst; bus.s_arid = id;
    while (!bus.s_arready && t < 50) begin @(negedge clk); t++; end
    if (!bus.s_arready) begin
      chk("ar_timeout", 32'd0, 32'd1);
      bus.s_arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    since = 1;
    while (got <= int'(len) && cyc < 1000) begin
      if (stalled) begin
        chk("stall_valid", 32'(bus.s_rvalid), 32'd1);
        chk("stall_data", bus.s_rdata, sd);
        chk("stall_resp", 32'(bus.s_rresp), 32'(sr));
        chk("stall_last", 32'(bus.s_rlast), 32'(sl));
        chk("stall_id", 32'(bus.s_rid), 32'(si));
        chk("stall_addr", mem_addr, sa);
      end
      if (bus.s_rvalid && !seen) begin
        seen = 1;
        if (lat_chk) chk("latency", 32'(since), 32'd2);
      end
      rr = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      bus.s_rready = rr;
      stalled = bus.s_rvalid && !rr;
      if (stalled) begin
        sd = bus.s_rdata; sr = bus.s_rresp; sl = bus.s_rlast; si = bus.s_rid; sa = mem_addr;
      end
      if (bus.s_rvalid && rr) begin
        chk("rdata", bus.s_rdata, ed[got]);
        chk("rresp", 32'(bus.s_rresp), 32'(er[got]));
        chk("rlast", 32'(bus.s_rlast), 32'(got == int'(len)));
        chk("rid", 32'(bus.s_rid), 32'(id));
        chk("arready", 32'(bus.s_arready), 32'(got == int'(len)));
        if (got == 0) begin d0 = bus.s_rdata; r0 = bus.s_rresp; end
        dl = bus.s_rdata; rl = bus.s_rresp;
        got++;
      end
      @(negedge clk);
      cyc++; since++;
    end
    bus.s_rready = 1'b0;
    if (got <= int'(len)) chk("beats", 32'(got), 32'(int'(len) + 1));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [31:0] d0, dl;
    logic [1:0]  r0, rl;
    int          t;
    bus.s_arvalid = 1'b0; bus.s_araddr = '0; bus.s_arlen = '0;
    bus.s_arsize = SIZE_4B; bus.s_arburst = BURST_INCR; bus.s_arid = '0; bus.s_rready = 1'b0;
    for (int i = 0; i < 262144; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'h88888888;
    for (int i = 0; i < 4; i++) mem[64 + i] = 32'h11110040 + 32'(i);
    mem[262143] = 32'hFFFC0DE0;
    tv[0] = '{32'h10,     8'd0, SIZE_4B, BURST_INCR,  4'h3, 0, 1'b1, 32'hDEADBEEF, RESP_OKAY,   32'hDEADBEEF, RESP_OKAY};
    tv[1] = '{32'h100,    8'd3, SIZE_4B, BURST_INCR,  4'h5, 0, 1'b1, 32'h11110040, RESP_OKAY,   32'h11110043, RESP_OKAY};
    tv[2] = '{32'h100,    8'd3, SIZE_4B, BURST_INCR,  4'h6, 1, 1'b0, 32'h11110040, RESP_OKAY,   32'h11110043, RESP_OKAY};
    tv[3] = '{32'hFFFFC,  8'd1, SIZE_4B, BURST_INCR,  4'h7, 0, 1'b1, 32'hFFFC0DE0, RESP_OKAY,   32'h0,        RESP_SLVERR};
    tv[4] = '{32'h40,     8'd2, 3'b001,  BURST_INCR,  4'h8, 0, 1'b1, 32'h0,        RESP_SLVERR, 32'h0,        RESP_SLVERR};
    tv[5] = '{32'h40,     8'd1, SIZE_4B, BURST_WRAP,  4'h9, 0, 1'b1, 32'h0,        RESP_SLVERR, 32'h0,        RESP_SLVERR};
    tv[6] = '{32'h20,     8'd3, SIZE_4B, BURST_FIXED, 4'hA, 1, 1'b0, 32'h88888888, RESP_OKAY,   32'h88888888, RESP_OKAY};
    tv[7] = '{32'h13,     8'd0, SIZE_4B, BURST_INCR,  4'h1, 0, 1'b1, 32'hDEADBEEF, RESP_OKAY,   32'hDEADBEEF, RESP_OKAY};
    #12;
    chk("rst_arready", 32'(bus.s_arready), 32'd0);
    chk("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    chk("rst_rdata", bus.s_rdata, 32'd0);
    chk("rst_rlast", 32'(bus.s_rlast), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arready_after_rst", 32'(bus.s_arready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      do_read(tv[k].addr, tv[k].len, tv[k].size, tv[k].burst, tv[k].id, tv[k].mode, tv[k].lat, d0, r0, dl, rl);
      chk($sformatf("tbl%0d_d0", k), d0, tv[k].d0);
      chk($sformatf("tbl%0d_r0", k), 32'(r0), 32'(tv[k].r0));
      chk($sformatf("tbl%0d_dl", k), dl, tv[k].dl);
      chk($sformatf("tbl%0d_rl", k), 32'(rl), 32'(tv[k].rl));
    end
    @(negedge clk);
    bus.s_arvalid = 1'b1; bus.s_araddr = 32'h200; bus.s_arlen = 8'd7;
    bus.s_arsize = SIZE_4B; bus.s_arburst = BURST_INCR; bus.s_arid = 4'hC;
    t = 0;
    while (!bus.s_arready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b1;
    t = 0;
    while (!bus.s_rvalid && t < 10) begin @(negedge clk); t++; end
    chk("mid_beat1_valid", 32'(bus.s_rvalid), 32'd1);
    chk("mid_beat1_data", bus.s_rdata, mem[128]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    chk("mid_rst_arready", 32'(bus.s_arready), 32'd0);
    chk("mid_rst_rdata", bus.s_rdata, 32'd0);
    chk("mid_rst_rlast", 32'(bus.s_rlast), 32'd0);
    chk("mid_rst_rid", 32'(bus.s_rid), 32'd0);
    chk("mid_rst_rresp", 32'(bus.s_rresp), 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_arready_pre", 32'(bus.s_arready), 32'd0);
    @(negedge clk);
    chk("rel_arready_edge", 32'(bus.s_arready), 32'd1);
    chk("rel_no_beats", 32'(bus.s_rvalid), 32'd0);
    bus.s_rready = 1'b0;
    do_read(32'h10, 8'd0, SIZE_4B, BURST_INCR, 4'h2, 0, 1'b1, d0, r0, dl, rl);
    chk("post_rst_data", d0, 32'hDEADBEEF);
    chk("post_rst_resp", 32'(r0), 32'(RESP_OKAY));
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      int          sel;
      sel = $urandom_range(0, 15);
      a = sel < 12 ? ($urandom & 32'h000FFFFF) : sel < 15 ? 32'h000FFFF0 + 32'($urandom_range(0, 15)) : $urandom;
      sz = $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) : SIZE_4B;
      do_read(a, 8'($urandom_range(0, 7)), sz, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              k % 3, 1'b0, d0, r0, dl, rl);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
